// File: rtl/rv4028_bus_responder.sv
// rv4028_bus_responder
//   Target on the RV4028 16-bit external bus. Decodes an address window in
//   memory or IO space and serves halfword read/write beats from a local
//   synchronous memory. Reads insert READ_WAIT wait states; writes take one
//   data cycle and honour per-byte lane masks. A sticky flag records
//   malformed requests (read+write together, or mismatched wr_n bits).
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   addr[31:0]       bus address (bit 0 always 0)
//   rd_n             read request, active-low
//   wr_n[1:0]        write request, active-low, both bits driven alike
//   msk_n[1:0]       byte lane mask, active-low ([1]=data[15:8], [0]=data[7:0])
//   iorq_n           IO space indicator
//   data_in[15:0]    write data (valid in the cycle after the address cycle)
//   data_out[15:0]   read data, holds its last value outside the data cycle
//   data_oe          responder drives read data this cycle
//   wait_n           low while a read is not ready
//   bus_err          sticky protocol error, cleared only by reset
module rv4028_bus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned READ_WAIT = 1,
  parameter int unsigned IO_SPACE  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        rd_n,
  input  logic [1:0]  wr_n,
  input  logic [1:0]  msk_n,
  input  logic        iorq_n,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        wait_n,
  output logic        bus_err
);

  localparam int unsigned IDX_W    = ADDR_BITS - 1;
  localparam int unsigned DEPTH    = 1 << IDX_W;
  localparam logic [3:0]  WAIT_LD  = 4'(READ_WAIT);
  localparam logic        IORQ_SEL = (IO_SPACE == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2,
    WR_DATA = 2'd3
  } state_t;

  logic [15:0]      r_mem [DEPTH];
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_msk;
  logic [15:0]      r_rdata;
  logic [3:0]       r_wcnt;

  logic             w_sel;
  logic [IDX_W-1:0] w_idx;
  logic             w_rd_req;
  logic             w_wr_req;
  logic             w_proto_err;
  logic             w_unused_addr0;

  assign w_sel          = (addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]) &&
                          (iorq_n == IORQ_SEL);
  assign w_idx          = addr[ADDR_BITS-1:1];
  assign w_rd_req       = !rd_n && (wr_n == 2'b11);
  assign w_wr_req       = rd_n && (wr_n != 2'b11);
  assign w_proto_err    = (!rd_n && (wr_n != 2'b11)) || (wr_n[1] != wr_n[0]);
  assign w_unused_addr0 = addr[0];

  // Beat sequencer. Outputs are registered so that wait_n/data_oe/data_out
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_msk    <= '1;
      r_rdata  <= '0;
      r_wcnt   <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      wait_n   <= 1'b1;
      bus_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel) begin
            if (w_proto_err) begin
              bus_err <= 1'b1;
            end else if (w_rd_req) begin
              r_idx   <= w_idx;
              r_rdata <= r_mem[w_idx];
              r_wcnt  <= WAIT_LD;
              if (WAIT_LD == 4'd0) begin
                // No wait states: present the data straight away.
                r_state  <= RD_DATA;
                data_oe  <= 1'b1;
                data_out <= r_mem[w_idx];
              end else begin
                r_state <= RD_WAIT;
                wait_n  <= 1'b0;
              end
            end else if (w_wr_req) begin
              r_idx   <= w_idx;
              r_msk   <= msk_n;
              r_state <= WR_DATA;
            end
          end
        end
        RD_WAIT: begin
          r_wcnt <= r_wcnt - 4'd1;
          if (r_wcnt == 4'd1) begin
            r_state  <= RD_DATA;
            wait_n   <= 1'b1;
            data_oe  <= 1'b1;
            data_out <= r_rdata;
          end
        end
        RD_DATA: begin
          data_oe <= 1'b0;
          r_state <= IDLE;
        end
        WR_DATA: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory is not reset. A reset during WR_DATA forces the state to IDLE
  // asynchronously, so an aborted write beat never commits.
  always_ff @(posedge clk) begin
    if (r_state == WR_DATA) begin
      if (!r_msk[1]) r_mem[r_idx][15:8] <= data_in[15:8];
      if (!r_msk[0]) r_mem[r_idx][7:0]  <= data_in[7:0];
    end
  end

endmodule

// File: tb/tb_rv4028_bus_responder.sv
// Bench for rv4028_bus_responder: three instances (READ_WAIT 1, 0, 3) on
// separate buses, a scoreboard queue of expected read data and a monitor
// that pops it whenever any instance asserts data_oe.
module tb_rv4028_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0][31:0] addr;
  logic [2:0]       rd_n;
  logic [2:0][1:0]  wr_n;
  logic [2:0][1:0]  msk_n;
  logic [2:0]       iorq_n;
  logic [2:0][15:0] data_in;
  logic [2:0][15:0] data_out;
  logic [2:0]       data_oe;
  logic [2:0]       wait_n;
  logic [2:0]       bus_err;

  rv4028_bus_responder #(.BASE_ADDR(32'h0), .ADDR_BITS(12), .READ_WAIT(1), .IO_SPACE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]),
    .msk_n(msk_n[0]), .iorq_n(iorq_n[0]), .data_in(data_in[0]), .data_out(data_out[0]),
    .data_oe(data_oe[0]), .wait_n(wait_n[0]), .bus_err(bus_err[0]));

  rv4028_bus_responder #(.BASE_ADDR(32'h0), .ADDR_BITS(12), .READ_WAIT(0), .IO_SPACE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]),
    .msk_n(msk_n[1]), .iorq_n(iorq_n[1]), .data_in(data_in[1]), .data_out(data_out[1]),
    .data_oe(data_oe[1]), .wait_n(wait_n[1]), .bus_err(bus_err[1]));

  rv4028_bus_responder #(.BASE_ADDR(32'h0), .ADDR_BITS(12), .READ_WAIT(3), .IO_SPACE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .addr(addr[2]), .rd_n(rd_n[2]), .wr_n(wr_n[2]),
    .msk_n(msk_n[2]), .iorq_n(iorq_n[2]), .data_in(data_in[2]), .data_out(data_out[2]),
    .data_oe(data_oe[2]), .wait_n(wait_n[2]), .bus_err(bus_err[2]));

  typedef struct {
    int          dut;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model [3][2048];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  // All instances decode the low 4 KiB of memory space.
  function automatic bit is_sel(input logic [31:0] a, input logic io);
    return (a[31:12] == 20'h0) && (io == 1'b1);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    addr = '0; rd_n = '1; wr_n = '1; msk_n = '1; iorq_n = '1; data_in = '0;
  endtask

  task automatic wr_beat(input int d, input logic [31:0] a, input logic [1:0] m,
                         input logic [15:0] dat, input logic io);
    int idx;
    addr[d] = a; rd_n[d] = 1'b1; wr_n[d] = 2'b00; msk_n[d] = m; iorq_n[d] = io;
    data_in[d] = ~dat;
    cyc();
    wr_n[d] = 2'b11; msk_n[d] = 2'b11; iorq_n[d] = 1'b1; addr[d] = $urandom;
    data_in[d] = dat;
    cyc();
    data_in[d] = 16'($urandom);
    if (is_sel(a, io)) begin
      idx = int'(a[11:1]);
      if (!m[1]) model[d][idx][15:8] = dat[15:8];
      if (!m[0]) model[d][idx][7:0]  = dat[7:0];
    end
  endtask

  task automatic rd_beat(input int d, input logic [31:0] a, input logic io, input bit keep);
    int   n;
    exp_t e;
    addr[d] = a; rd_n[d] = 1'b0; wr_n[d] = 2'b11; iorq_n[d] = io;
    if (is_sel(a, io)) begin
      e.dut  = d;
      e.data = model[d][int'(a[11:1])];
      exp_q.push_back(e);
      cyc();
      n = 0;
      while (wait_n[d] == 1'b0 && n < 40) begin
        n++;
        cyc();
      end
      chk($sformatf("rd_waits_dut%0d", d), n, wait_of(d));
      chk($sformatf("rd_oe_dut%0d", d), {31'd0, data_oe[d]}, 32'd1);
      cyc();
      if (!keep) rd_n[d] = 1'b1;
    end else begin
      repeat (3) begin
        cyc();
        chk($sformatf("nosel_oe_dut%0d", d), {31'd0, data_oe[d]}, 32'd0);
        chk($sformatf("nosel_wait_dut%0d", d), {31'd0, wait_n[d]}, 32'd1);
      end
      rd_n[d] = 1'b1;
    end
  endtask

  // Scoreboard monitor: every data cycle on any instance consumes one entry.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (data_oe[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_read dut%0d: got data %h, expected no data cycle", d, data_out[d]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_dut_id", d, e.dut);
          chk($sformatf("rd_data_dut%0d", d), {16'd0, data_out[d]}, {16'd0, e.data});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;

    idle_bus();
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_wait_n", {31'd0, wait_n[d]}, 32'd1);
      chk("rst_data_oe", {31'd0, data_oe[d]}, 32'd0);
      chk("rst_data_out", {16'd0, data_out[d]}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err[d]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read with one wait state.
    wr_beat(0, 32'h10, 2'b00, 16'hBEEF, 1'b1);
    rd_beat(0, 32'h10, 1'b1, 1'b0);

    // Byte mask: only the upper lane is written.
    wr_beat(0, 32'h20, 2'b00, 16'h1234, 1'b1);
    wr_beat(0, 32'h20, 2'b01, 16'hAB56, 1'b1);
    chk("mask_model", {16'd0, model[0][16]}, 32'h0000_AB34);
    rd_beat(0, 32'h20, 1'b1, 1'b0);

    // 32-bit access with no wait states, rd_n held across both beats.
    wr_beat(1, 32'h30, 2'b00, 16'h5678, 1'b1);
    wr_beat(1, 32'h32, 2'b00, 16'h9ABC, 1'b1);
    rd_beat(1, 32'h30, 1'b1, 1'b1);
    rd_beat(1, 32'h32, 1'b1, 1'b0);

    // Decode: out of window, then wrong space, then a normal read.
    rd_beat(0, 32'h8000_0010, 1'b1, 1'b0);
    rd_beat(0, 32'h0000_0010, 1'b0, 1'b0);
    wr_beat(0, 32'h0000_0010, 2'b00, 16'h0BAD, 1'b0);
    rd_beat(0, 32'h0000_0010, 1'b1, 1'b0);

    // Protocol errors: read+write together, then mismatched wr_n bits.
    wr_beat(0, 32'h50, 2'b00, 16'h1111, 1'b1);
    wr_beat(1, 32'h52, 2'b00, 16'h2222, 1'b1);
    chk("perr_pre", {31'd0, bus_err[0]}, 32'd0);
    addr[0] = 32'h50; rd_n[0] = 1'b0; wr_n[0] = 2'b00; msk_n[0] = 2'b00; data_in[0] = 16'hFFFF;
    cyc();
    rd_n[0] = 1'b1; wr_n[0] = 2'b11; msk_n[0] = 2'b11;
    chk("perr_oe", {31'd0, data_oe[0]}, 32'd0);
    chk("perr_wait", {31'd0, wait_n[0]}, 32'd1);
    cyc();
    chk("perr_set", {31'd0, bus_err[0]}, 32'd1);
    addr[1] = 32'h52; rd_n[1] = 1'b1; wr_n[1] = 2'b01; msk_n[1] = 2'b00; data_in[1] = 16'hFFFF;
    cyc();
    wr_n[1] = 2'b11; msk_n[1] = 2'b11;
    cyc();
    chk("perr_wrn_set", {31'd0, bus_err[1]}, 32'd1);
    rd_beat(0, 32'h50, 1'b1, 1'b0);
    rd_beat(1, 32'h52, 1'b1, 1'b0);
    chk("perr_sticky0", {31'd0, bus_err[0]}, 32'd1);
    chk("perr_sticky1", {31'd0, bus_err[1]}, 32'd1);

    // Reset during a write data cycle: the write must not commit.
    wr_beat(0, 32'h60, 2'b00, 16'hC0DE, 1'b1);
    addr[0] = 32'h60; wr_n[0] = 2'b00; msk_n[0] = 2'b00;
    cyc();
    wr_n[0] = 2'b11; msk_n[0] = 2'b11; data_in[0] = 16'hDEAD;
    #2 rst_n = 1'b0;
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    idle_bus();
    chk("rst_clears_err", {31'd0, bus_err[0]}, 32'd0);
    rd_beat(0, 32'h60, 1'b1, 1'b0);

    // Reset while waiting on a three-wait-state read.
    wr_beat(2, 32'h40, 2'b00, 16'h7E57, 1'b1);
    rd_beat(2, 32'h10, 1'b1, 1'b0);
    addr[2] = 32'h40; rd_n[2] = 1'b0; wr_n[2] = 2'b11;
    cyc();
    chk("rw3_wait_low1", {31'd0, wait_n[2]}, 32'd0);
    cyc();
    chk("rw3_wait_low2", {31'd0, wait_n[2]}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wait", {31'd0, wait_n[2]}, 32'd1);
    chk("midrst_oe", {31'd0, data_oe[2]}, 32'd0);
    chk("midrst_dout", {16'd0, data_out[2]}, 32'd0);
    rd_n[2] = 1'b1;
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_beat(2, 32'h40, 1'b1, 1'b0);

    // Randomized traffic against the model on each instance.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++)
        wr_beat(d, 32'h100 + 32'(2 * i), 2'b00, 16'($urandom), 1'b1);
      for (int k = 0; k < 40; k++) begin
        a  = 32'h100 + 32'(2 * $urandom_range(0, 15));
        op = int'($urandom_range(0, 9));
        if (op <= 2) begin
          wr_beat(d, a, 2'($urandom), 16'($urandom), 1'b1);
        end else if (op == 3) begin
          wr_beat(d, a, 2'b00, 16'($urandom), 1'b0);
        end else if (op <= 6) begin
          rd_beat(d, a, 1'b1, 1'b0);
        end else if (op <= 8) begin
          rd_beat(d, a & ~32'h2, 1'b1, 1'b1);
          rd_beat(d, a | 32'h2, 1'b1, 1'b0);
        end else begin
          rd_beat(d, a | 32'h0010_0000, 1'b1, 1'b0);
        end
      end
    end

    repeat (5) cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
